// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, runs one req/ack fetch at a time and
// presents the fetched word to decode over a valid/ready handshake with redirects.
module instr_fetch_unit #(
    parameter int unsigned              PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]      RESET_PC = {PC_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic                instr_valid,
    input  logic                decode_ready,
    output logic [31:0]         instr,
    output logic [6:0]          opcode,
    output logic [PC_WIDTH-1:0] instr_pc,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   addr_q, addr_d;
    logic                  squash_q, squash_d;
    logic                  req_q, req_d;
    logic                  valid_q, valid_d;
    logic [31:0]           instr_q, instr_d;
    logic [PC_WIDTH-1:0]   instr_pc_q, instr_pc_d;

    logic [PC_WIDTH-1:0]   redirect_tgt_s;
    logic                  handshake_s;
    logic                  capture_s;
    logic                  unused_low_s;

    assign redirect_tgt_s = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    assign unused_low_s   = ^redirect_pc[1:0];
    assign handshake_s    = valid_q & decode_ready;
    // A returning word is kept only if it was neither squashed earlier nor redirected now.
    assign capture_s      = (state_q == S_WAIT) & imem_ack & ~squash_q & ~redirect_valid;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            squash_q   <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= 32'd0;
            instr_pc_q <= {PC_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            squash_q   <= squash_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (redirect_valid) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    if (squash_q || redirect_valid) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ISSUE: begin
                if (redirect_valid || handshake_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Next values for the registered outputs, PC and squash flag.
    always_comb begin
        pc_d       = pc_q;
        squash_d   = squash_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        if (redirect_valid) begin
            pc_d = redirect_tgt_s;
        end else if (handshake_s) begin
            pc_d = pc_q + {{(PC_WIDTH-3){1'b0}}, 3'b100};
        end else begin
            pc_d = pc_q;
        end

        case (state_q)
            S_WAIT: begin
                if (imem_ack) begin
                    squash_d = 1'b0;
                end else if (redirect_valid) begin
                    squash_d = 1'b1;
                end else begin
                    squash_d = squash_q;
                end
            end
            default: squash_d = 1'b0;
        endcase

        if (redirect_valid) begin
            valid_d = 1'b0;
        end else if (capture_s) begin
            valid_d = 1'b1;
        end else if (handshake_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (capture_s) begin
            instr_d    = imem_rdata;
            instr_pc_d = addr_q;
        end else begin
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
        end

        // An in-flight request keeps its address even after a redirect moves the PC.
        if ((state_q == S_WAIT) && (state_d == S_WAIT)) begin
            addr_d = addr_q;
        end else begin
            addr_d = pc_d;
        end

        req_d = (state_d == S_WAIT);
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign opcode      = valid_q ? instr_q[6:0] : 7'd0;

endmodule
